ram_s1pnc_be: RTL and testbench
===============================

# ram_s1pnc_be

Single-clock simple-dual-port RAM: one byte-enabled write port, `READ_PORTS` independent read ports, programmable read latency and a selectable read-during-write policy. A built-in clear engine zeroes the whole array on request. It is the general-purpose buffer RAM for datapath blocks that need several readers, partial-word updates or a fast bulk wipe without software loops.

## Interface
- `WORD_WIDTH`, 32, data word width; must be a multiple of `BYTE_WIDTH`.
- `BYTE_WIDTH`, 8, bits per write-enable lane.
- `WORD_COUNT`, 256, number of words; need not be a power of two.
- `READ_PORTS`, 2, number of read ports (1..4).
- `READ_LATENCY`, 1, cycles from read request to data (1..3).
- `RDW_MODE`, 0, same-address read/write: 0 = old data, 1 = new data.
- `INIT_FILE`, "", memory image path; empty = no init.
- `INIT_FILE_BIN`, 0, 1 = binary image, 0 = hex image.
- Local: `ADDR_WIDTH` = $clog2(WORD_COUNT), `BE_WIDTH` = WORD_WIDTH/BYTE_WIDTH.
- The block has one clock; reset is synchronous and active-high.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous active-high reset.
- `we_i`  in  1  write request.
- `be_i`  in  BE_WIDTH  byte-lane enables for the write.
- `waddr_i`  in  ADDR_WIDTH  write address.
- `wdata_i`  in  WORD_WIDTH  write data.
- `re_i`  in  [READ_PORTS]  per-port read request.
- `raddr_i`  in  [READ_PORTS][ADDR_WIDTH]  per-port read address.
- `rdata_o`  out  [READ_PORTS][WORD_WIDTH]  per-port read data.
- `rvalid_o`  out  [READ_PORTS]  per-port read data valid, one-cycle pulse per request.
- `clr_i`  in  1  start array clear.
- `busy_o`  out  1  clear in progress.

## Operation
- Reset: `rvalid_o` = 0, `rdata_o` = 0, `busy_o` = 0, clear FSM to IDLE, read pipelines flushed. Array contents are not reset; they keep the init image or prior data.
- Write: when `we_i` is high and `busy_o` is low, lanes with `be_i[k]` = 1 take `wdata_i[k]`; other lanes are unchanged. `be_i` = 0 means no-op.
- Read: when `re_i[p]` is high and `busy_o` is low, the addressed word is returned on port p after `READ_LATENCY`. `rdata_o[p]` holds its last valid value between pulses.
- Out-of-range addresses (≥ `WORD_COUNT`): writes are dropped. Reads return 0 with `rvalid_o` asserted.
- Read-during-write, same address, same cycle: if `RDW_MODE` = 0, the read returns the pre-write word. If `RDW_MODE` = 1, the read returns the merged word: enabled lanes new, others old. Several ports reading the write address all follow the same rule.
- Clear FSM:
  - IDLE: `clr_i` moves it to CLEAR.
  - CLEAR: writes 0 to address counter `c` = 0, 1, … `WORD_COUNT`-1, one word per cycle, all lanes. After the last address it returns to IDLE.
  - `clr_i` is ignored while in CLEAR.
  - `we_i` and `re_i` are ignored while `busy_o` is high. Requests issued while busy produce no `rvalid_o`.
- `clr_i` and `we_i` in the same IDLE cycle: the write is performed and the clear starts next cycle, so the written word ends up 0.
- Reads issued before the clear starts complete normally with the data sampled at issue time.
- Reset during CLEAR: FSM goes to IDLE, `busy_o` drops next cycle, and addresses beyond the counter keep their old contents.

## Timing
- `re_i[p]` high in cycle n → `rvalid_o[p]` and `rdata_o[p]` valid in cycle n+`READ_LATENCY`. Back-to-back requests give back-to-back pulses, full throughput per port.
- A write in cycle n is visible to a read issued in cycle n+1 (either mode), and to cycle n under `RDW_MODE` = 1.
- `clr_i` high in cycle n with `busy_o` low → `busy_o` high in cycles n+1 … n+`WORD_COUNT`. Address i is zeroed at the end of cycle n+1+i. The first accepted request is in cycle n+`WORD_COUNT`+1.

## Structure
- Package `ram_pkg`: `rdw_mode_e` (RDW_OLD, RDW_NEW) and `clr_state_e` (CLR_IDLE, CLR_RUN).
- Sub-module `ram_rd_pipe`: per-port delay line carrying valid and data through `READ_LATENCY`-1 extra register stages. Instantiated `READ_PORTS` times.
- Top level: array, write-merge logic, RDW forwarding mux, clear FSM, and the address counter with width `ADDR_WIDTH`, terminal count `WORD_COUNT`-1.

## Test plan
- Full word write, then read: write 0xDEADBEEF to 5 with `be_i` = 0xF, read addr 5 on port 0 with `READ_LATENCY` = 3 → `rvalid_o[0]` exactly 3 cycles later, data 0xDEADBEEF.
- Partial write, read-old: word 7 = 0x11223344, write 0xAABBCCDD `be_i` = 0x5 while ports 0 and 1 read 7 in the same cycle, `RDW_MODE` = 0 → both ports return 0x11223344, and the next read returns 0x11BB33DD.
- Partial write, read-new: same stimulus with `RDW_MODE` = 1 → same-cycle reads return 0x11BB33DD.
- Clear: `clr_i` pulse with `WORD_COUNT` = 256 → `busy_o` high exactly 256 cycles, requests during busy give no `rvalid_o`, reads of addr 0/255 afterward return 0.
- Reset mid-clear: assert `rst_i` after 10 clear cycles → addresses 0..9 read 0, address 200 keeps its prior value, `busy_o` low.
- Out-of-range access, `WORD_COUNT` = 200: write to 250 → no array change; read 250 → data 0 with `rvalid_o` asserted.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types for the byte-enabled multi-reader RAM.
//   rdw_mode_e  : same-address read-during-write policy
//   clr_state_e : states of the bulk clear engine
package ram_pkg;

  typedef enum logic {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-data delay line: carries a valid pulse and its data through STAGES
// extra register stages. Data registers only load with valid, so the output
// holds the last returned word between pulses.
//   clk_i, rst_i : clock, synchronous active-high reset
//   valid_i      : valid from the array read register
//   data_i       : data from the array read register
//   valid_o      : delayed valid
//   data_o       : delayed data (held between pulses)
module ram_rd_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  if (STAGES == 0) begin : g_bypass
    assign valid_o = valid_i;
    assign data_o  = data_i;
  end else begin : g_stages
    logic             v_q [STAGES];
    logic [WIDTH-1:0] d_q [STAGES];

    // Shift register; each data stage loads only when its upstream valid is set
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < int'(STAGES); i++) begin
          v_q[i] <= 1'b0;
          d_q[i] <= '0;
        end
      end else begin
        v_q[0] <= valid_i;
        if (valid_i) d_q[0] <= data_i;
        for (int i = 1; i < int'(STAGES); i++) begin
          v_q[i] <= v_q[i-1];
          if (v_q[i-1]) d_q[i] <= d_q[i-1];
        end
      end
    end

    assign valid_o = v_q[STAGES-1];
    assign data_o  = d_q[STAGES-1];
  end

endmodule

// File: rtl/ram_s1pnc_be.sv
// Single-clock RAM with one byte-enabled write port, READ_PORTS independent
// read ports, READ_LATENCY-cycle reads, selectable read-during-write policy
// and a clear engine that zeroes one word per cycle.
//   clk_i, rst_i : clock, synchronous active-high reset
//   we_i, be_i, waddr_i, wdata_i : write request, lane enables, address, data
//   re_i, raddr_i : per-port read request and address
//   rdata_o, rvalid_o : per-port read data (held) and one-cycle valid
//   clr_i : start array clear;  busy_o : clear in progress
// Array contents are never reset. INIT_FILE / INIT_FILE_BIN describe the
// preload image; the image is applied by the memory macro flow, not here.
module ram_s1pnc_be
  import ram_pkg::*;
#(
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned BYTE_WIDTH    = 8,
  parameter int unsigned WORD_COUNT    = 256,
  parameter int unsigned READ_PORTS    = 2,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned RDW_MODE      = 0,
  parameter string       INIT_FILE     = "",
  parameter int unsigned INIT_FILE_BIN = 0,
  localparam int unsigned ADDR_WIDTH   = $clog2(WORD_COUNT),
  localparam int unsigned BE_WIDTH     = WORD_WIDTH / BYTE_WIDTH
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  we_i,
  input  logic [BE_WIDTH-1:0]                   be_i,
  input  logic [ADDR_WIDTH-1:0]                 waddr_i,
  input  logic [WORD_WIDTH-1:0]                 wdata_i,
  input  logic [READ_PORTS-1:0]                 re_i,
  input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0] raddr_i,
  output logic [READ_PORTS-1:0][WORD_WIDTH-1:0] rdata_o,
  output logic [READ_PORTS-1:0]                 rvalid_o,
  input  logic                                  clr_i,
  output logic                                  busy_o
);

  localparam rdw_mode_e             RDW        = (RDW_MODE != 0) ? RDW_NEW : RDW_OLD;
  localparam logic [ADDR_WIDTH:0]   WORD_LIMIT = (ADDR_WIDTH+1)'(WORD_COUNT);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(WORD_COUNT - 1);

  // Preload configuration is consumed by the macro flow only
  logic unused_init_cfg;
  assign unused_init_cfg = (INIT_FILE != "") ^ (INIT_FILE_BIN != 0);

  logic [WORD_WIDTH-1:0] mem [WORD_COUNT];

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;

  logic                  wr_in_range_c;
  logic                  wr_go_c;
  logic [WORD_WIDTH-1:0] wr_old_c;
  logic [WORD_WIDTH-1:0] wr_merged_c;

  assign wr_in_range_c = {1'b0, waddr_i} < WORD_LIMIT;
  assign wr_go_c       = we_i & ~busy_q & wr_in_range_c & (|be_i);
  assign wr_old_c      = wr_in_range_c ? mem[waddr_i] : '0;

  // Byte-lane merge: enabled lanes from wdata_i, the rest from the stored word
  always_comb begin
    wr_merged_c = wr_old_c;
    for (int k = 0; k < int'(BE_WIDTH); k++) begin
      if (be_i[k]) wr_merged_c[k*BYTE_WIDTH +: BYTE_WIDTH] = wdata_i[k*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Array update: clear engine owns the write port while running
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == CLR_RUN) mem[cnt_q] <= '0;
      else if (wr_go_c)       mem[waddr_i] <= wr_merged_c;
    end
  end

  // Clear FSM next-state and counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLR_IDLE: begin
        if (clr_i) begin
          state_d = CLR_RUN;
          cnt_d   = '0;
        end
      end
      CLR_RUN: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = CLR_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = CLR_IDLE;
    endcase
    busy_d = (state_d == CLR_RUN);
  end

  // Clear FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o = busy_q;

  for (genvar p = 0; p < int'(READ_PORTS); p++) begin : g_port
    logic                  rd_in_range_c;
    logic                  rd_go_c;
    logic [WORD_WIDTH-1:0] rd_word_c;
    logic                  rvalid_q;
    logic [WORD_WIDTH-1:0] rdata_q;

    assign rd_in_range_c = {1'b0, raddr_i[p]} < WORD_LIMIT;
    assign rd_go_c       = re_i[p] & ~busy_q;

    // Out-of-range reads return zero; same-address forwarding only in new-data mode
    always_comb begin
      rd_word_c = '0;
      if (rd_in_range_c) begin
        if (RDW == RDW_NEW && wr_go_c && raddr_i[p] == waddr_i) rd_word_c = wr_merged_c;
        else                                                     rd_word_c = mem[raddr_i[p]];
      end
    end

    // First read stage samples the array at issue time
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= rd_go_c;
        if (rd_go_c) rdata_q <= rd_word_c;
      end
    end

    ram_rd_pipe #(
      .WIDTH  (WORD_WIDTH),
      .STAGES (READ_LATENCY - 1)
    ) u_pipe (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (rvalid_q),
      .data_i  (rdata_q),
      .valid_o (rvalid_o[p]),
      .data_o  (rdata_o[p])
    );
  end

endmodule

// File: tb/tb_ram_s1pnc_be.sv
// Directed bench: three RAM configurations share one stimulus stream.
//   a: latency 3, old-data RDW, 256 words
//   b: latency 1, new-data RDW, 256 words
//   c: latency 2, old-data RDW, 200 words (addresses >= 200 out of range)
module tb_ram_s1pnc_be;

  logic            clk = 1'b0;
  logic            rst;
  logic            we;
  logic [3:0]      be;
  logic [7:0]      waddr;
  logic [31:0]     wdata;
  logic [1:0]      re;
  logic [1:0][7:0] raddr;
  logic            clr;

  logic [1:0][31:0] rdata_a, rdata_b, rdata_c;
  logic [1:0]       rvalid_a, rvalid_b, rvalid_c;
  logic             busy_a, busy_b, busy_c;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_s1pnc_be #(.READ_LATENCY(3), .RDW_MODE(0), .WORD_COUNT(256)) u_a (
    .clk_i(clk), .rst_i(rst), .we_i(we), .be_i(be), .waddr_i(waddr), .wdata_i(wdata),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata_a), .rvalid_o(rvalid_a), .clr_i(clr), .busy_o(busy_a));

  ram_s1pnc_be #(.READ_LATENCY(1), .RDW_MODE(1), .WORD_COUNT(256)) u_b (
    .clk_i(clk), .rst_i(rst), .we_i(we), .be_i(be), .waddr_i(waddr), .wdata_i(wdata),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata_b), .rvalid_o(rvalid_b), .clr_i(clr), .busy_o(busy_b));

  ram_s1pnc_be #(.READ_LATENCY(2), .RDW_MODE(0), .WORD_COUNT(200)) u_c (
    .clk_i(clk), .rst_i(rst), .we_i(we), .be_i(be), .waddr_i(waddr), .wdata_i(wdata),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata_c), .rvalid_o(rvalid_c), .clr_i(clr), .busy_o(busy_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1; be = b; waddr = a; wdata = d;
    tick();
    we = 1'b0; be = '0;
  endtask

  // One issue cycle (optional write alongside), then checks each config at its latency
  task automatic cycle_rd(input string tag, input logic we_v, input logic [3:0] be_v,
                          input logic [7:0] wa, input logic [31:0] wd, input logic [1:0] re_v,
                          input logic [7:0] a0, input logic [7:0] a1,
                          input logic [31:0] ea0, input logic [31:0] ea1,
                          input logic [31:0] eb0, input logic [31:0] eb1,
                          input logic [31:0] ec0, input logic [31:0] ec1);
    we = we_v; be = be_v; waddr = wa; wdata = wd;
    re = re_v; raddr[0] = a0; raddr[1] = a1;
    tick();
    we = 1'b0; be = '0; re = '0;
    chk({tag, " b_valid"}, 32'(rvalid_b), 32'(re_v));
    chk({tag, " a_early"}, 32'(rvalid_a), 32'd0);
    chk({tag, " c_early"}, 32'(rvalid_c), 32'd0);
    if (re_v[0]) chk({tag, " b_d0"}, rdata_b[0], eb0);
    if (re_v[1]) chk({tag, " b_d1"}, rdata_b[1], eb1);
    tick();
    chk({tag, " c_valid"}, 32'(rvalid_c), 32'(re_v));
    chk({tag, " a_early2"}, 32'(rvalid_a), 32'd0);
    if (re_v[0]) chk({tag, " c_d0"}, rdata_c[0], ec0);
    if (re_v[1]) chk({tag, " c_d1"}, rdata_c[1], ec1);
    tick();
    chk({tag, " a_valid"}, 32'(rvalid_a), 32'(re_v));
    chk({tag, " b_pulse_end"}, 32'(rvalid_b), 32'd0);
    if (re_v[0]) chk({tag, " a_d0"}, rdata_a[0], ea0);
    if (re_v[1]) chk({tag, " a_d1"}, rdata_a[1], ea1);
    if (re_v[0]) chk({tag, " b_hold0"}, rdata_b[0], eb0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bc_a, bc_b, bc_c, rv_a, rv_b, rv_c;
    rst = 1'b1; we = 1'b0; be = '0; waddr = '0; wdata = '0;
    re = '0; raddr = '0; clr = 1'b0;
    tick(); tick();
    chk("rst rvalid_a", 32'(rvalid_a), 32'd0);
    chk("rst rvalid_b", 32'(rvalid_b), 32'd0);
    chk("rst rdata_a0", rdata_a[0], 32'd0);
    chk("rst rdata_b1", rdata_b[1], 32'd0);
    chk("rst rdata_c0", rdata_c[0], 32'd0);
    chk("rst busy", 32'({busy_a, busy_b, busy_c}), 32'd0);
    rst = 1'b0;
    tick();

    // Full-word write then read with per-config latency
    wr(8'd5, 32'hDEADBEEF, 4'hF);
    wr(8'd7, 32'h11223344, 4'hF);
    cycle_rd("rd5", 1'b0, 4'h0, 8'd0, 32'd0, 2'b01, 8'd5, 8'd0,
             32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 32'd0);

    // Partial write with both ports reading the same address in that cycle
    cycle_rd("rdw", 1'b1, 4'h5, 8'd7, 32'hAABBCCDD, 2'b11, 8'd7, 8'd7,
             32'h11223344, 32'h11223344, 32'h11BB33DD, 32'h11BB33DD,
             32'h11223344, 32'h11223344);
    cycle_rd("after_rdw", 1'b0, 4'h0, 8'd0, 32'd0, 2'b11, 8'd7, 8'd5,
             32'h11BB33DD, 32'hDEADBEEF, 32'h11BB33DD, 32'hDEADBEEF,
             32'h11BB33DD, 32'hDEADBEEF);

    // Back-to-back requests on port 1 give back-to-back pulses
    re = 2'b10; raddr[1] = 8'd5;
    tick();
    raddr[1] = 8'd7;
    chk("b2b first_v", 32'(rvalid_b), 32'h2);
    chk("b2b first_d", rdata_b[1], 32'hDEADBEEF);
    tick();
    re = '0;
    chk("b2b second_v", 32'(rvalid_b), 32'h2);
    chk("b2b second_d", rdata_b[1], 32'h11BB33DD);
    chk("b2b c_first_d", rdata_c[1], 32'hDEADBEEF);
    tick(); tick();

    // Address 250 is out of range only for config c
    wr(8'd250, 32'h12345678, 4'hF);
    cycle_rd("oor", 1'b0, 4'h0, 8'd0, 32'd0, 2'b11, 8'd250, 8'd5,
             32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF,
             32'h00000000, 32'hDEADBEEF);

    // be = 0 is a no-op; single upper lane update
    wr(8'd5, 32'hFFFFFFFF, 4'h0);
    wr(8'd7, 32'hEE000000, 4'h8);
    cycle_rd("lanes", 1'b0, 4'h0, 8'd0, 32'd0, 2'b11, 8'd5, 8'd7,
             32'hDEADBEEF, 32'hEEBB33DD, 32'hDEADBEEF, 32'hEEBB33DD,
             32'hDEADBEEF, 32'hEEBB33DD);

    // Reset after ten clear cycles
    wr(8'd0,   32'h01010101, 4'hF);
    wr(8'd9,   32'h09090909, 4'hF);
    wr(8'd50,  32'h32323232, 4'hF);
    wr(8'd200, 32'hCAFEF00D, 4'hF);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("midclr busy_start", 32'({busy_a, busy_b, busy_c}), 32'h7);
    repeat (9) tick();
    chk("midclr busy_10", 32'({busy_a, busy_b, busy_c}), 32'h7);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midclr busy_drop", 32'({busy_a, busy_b, busy_c}), 32'h0);
    cycle_rd("midclr lo", 1'b0, 4'h0, 8'd0, 32'd0, 2'b11, 8'd0, 8'd9,
             32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    cycle_rd("midclr hi", 1'b0, 4'h0, 8'd0, 32'd0, 2'b11, 8'd50, 8'd200,
             32'h32323232, 32'hCAFEF00D, 32'h32323232, 32'hCAFEF00D,
             32'h32323232, 32'h00000000);

    // Full clear with a coincident write; requests during busy are ignored
    clr = 1'b1; we = 1'b1; be = 4'hF; waddr = 8'd100; wdata = 32'h77777777;
    tick();
    clr = 1'b0; we = 1'b0; be = '0;
    re = 2'b11; raddr[0] = 8'd100; raddr[1] = 8'd100;
    bc_a = 0; bc_b = 0; bc_c = 0; rv_a = 0; rv_b = 0; rv_c = 0;
    for (int i = 0; i < 300; i++) begin
      if (busy_a) begin bc_a++; if (rvalid_a != 0) rv_a++; end
      if (busy_b) begin bc_b++; if (rvalid_b != 0) rv_b++; end
      if (busy_c) begin bc_c++; if (rvalid_c != 0) rv_c++; end
      tick();
    end
    re = '0;
    tick(); tick(); tick();
    chk("clr busy_cycles_a", 32'(bc_a), 32'd256);
    chk("clr busy_cycles_b", 32'(bc_b), 32'd256);
    chk("clr busy_cycles_c", 32'(bc_c), 32'd200);
    chk("clr rvalid_busy_a", 32'(rv_a), 32'd0);
    chk("clr rvalid_busy_b", 32'(rv_b), 32'd0);
    chk("clr rvalid_busy_c", 32'(rv_c), 32'd0);
    chk("clr busy_end", 32'({busy_a, busy_b, busy_c}), 32'h0);
    cycle_rd("clr ends", 1'b0, 4'h0, 8'd0, 32'd0, 2'b11, 8'd0, 8'd255,
             32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    cycle_rd("clr mid", 1'b0, 4'h0, 8'd0, 32'd0, 2'b11, 8'd100, 8'd199,
             32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
